// File: rtl/ib_rom_port_sched_if.sv
// Requester-side and ROM-side bundle of the IB ROM port scheduler.
// slave = scheduler view, master = requesters plus ROM bank view.
interface ib_rom_port_sched_if #(
    parameter int N_REQ   = 4,
    parameter int ADDR_BW = 5,
    parameter int DATA_BW = 6
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*ADDR_BW-1:0] req_addr;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ*DATA_BW-1:0] rsp_data;
    logic [ADDR_BW-1:0]       rom_portA_addr;
    logic [ADDR_BW-1:0]       rom_portB_addr;
    logic [DATA_BW-1:0]       rom_portA_dout;
    logic [DATA_BW-1:0]       rom_portB_dout;

    modport master (
        output req_valid, req_addr, rom_portA_dout, rom_portB_dout,
        input  req_ready, rsp_valid, rsp_data, rom_portA_addr, rom_portB_addr
    );

    modport slave (
        input  req_valid, req_addr, rom_portA_dout, rom_portB_dout,
        output req_ready, rsp_valid, rsp_data, rom_portA_addr, rom_portB_addr
    );
endinterface

// File: rtl/ib_rom_port_sched.sv
// Dual-port IB lookup ROM read scheduler: round-robin 2 grants/cycle, tag-routed responses,
// drained iteration-table switch. Optional macro ARB_STATS_EN adds the stall_cnt counter.
module ib_rom_port_sched #(
    parameter int N_REQ   = 4,
    parameter int ADDR_BW = 5,
    parameter int DATA_BW = 6,
    parameter int ROM_LAT = 1
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_BW  = 16
`endif
) (
    input  logic                 read_clk,
    input  logic                 rstn,
    ib_rom_port_sched_if.slave   bus,
    input  logic                 iter_switch_req,
    output logic                 iter_switch_done,
    output logic                 iter_sel,
    output logic                 busy
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_BW-1:0]    stall_cnt
`endif
);
    localparam int ID_BW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t                        state_reg;
    logic                          iter_sel_reg;
    logic                          iter_switch_done_reg;
    logic [ID_BW-1:0]              rr_ptr_reg;
    logic [ID_BW-1:0]              rr_ptr_next;
    logic [ID_BW-1:0]              last_id;
    logic                          arb_en;
    logic                          grant_a_vld;
    logic                          grant_b_vld;
    logic [ID_BW-1:0]              grant_a_id;
    logic [ID_BW-1:0]              grant_b_id;
    logic [ID_BW:0]                scan_sum;
    logic [ID_BW-1:0]              scan_id;
    logic [ADDR_BW-1:0]            req_addr_arr [N_REQ];
    logic [ADDR_BW-1:0]            rom_a_addr_reg;
    logic [ADDR_BW-1:0]            rom_b_addr_reg;
    logic [ROM_LAT:0]              tag_a_vld_reg;
    logic [ROM_LAT:0]              tag_b_vld_reg;
    logic [ROM_LAT:0][ID_BW-1:0]   tag_a_id_reg;
    logic [ROM_LAT:0][ID_BW-1:0]   tag_b_id_reg;
    logic [ID_BW-1:0]              tag_a_out;
    logic [ID_BW-1:0]              tag_b_out;
    logic [N_REQ-1:0]              hit_a;
    logic [N_REQ-1:0]              hit_b;
    logic                          drain_done;

    // Grants only while running and out of reset; reset forces every ready low.
    assign arb_en = rstn && (state_reg == ST_RUN);

    always_comb begin
        grant_a_vld = 1'b0;
        grant_b_vld = 1'b0;
        grant_a_id  = '0;
        grant_b_id  = '0;
        scan_sum    = '0;
        scan_id     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (ID_BW+1)'(k);
            if (scan_sum >= (ID_BW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (ID_BW+1)'(N_REQ);
            end
            scan_id = scan_sum[ID_BW-1:0];
            if (arb_en && bus.req_valid[scan_id]) begin
                if (!grant_a_vld) begin
                    grant_a_vld = 1'b1;
                    grant_a_id  = scan_id;
                end else if (!grant_b_vld) begin
                    grant_b_vld = 1'b1;
                    grant_b_id  = scan_id;
                end
            end
        end
    end

    assign last_id     = grant_b_vld ? grant_b_id : grant_a_id;
    assign rr_ptr_next = (last_id == ID_BW'(N_REQ - 1)) ? '0 : last_id + ID_BW'(1);

    // Slot 0 of each tag pipe lines up with the registered ROM address; the last slot with dout.
    always_ff @(posedge read_clk) begin
        if (!rstn) begin
            rr_ptr_reg     <= '0;
            rom_a_addr_reg <= '0;
            rom_b_addr_reg <= '0;
            tag_a_vld_reg  <= '0;
            tag_b_vld_reg  <= '0;
            tag_a_id_reg   <= '0;
            tag_b_id_reg   <= '0;
        end else begin
            if (grant_a_vld) begin
                rr_ptr_reg     <= rr_ptr_next;
                rom_a_addr_reg <= req_addr_arr[grant_a_id];
            end
            if (grant_b_vld) begin
                rom_b_addr_reg <= req_addr_arr[grant_b_id];
            end
            tag_a_vld_reg <= {tag_a_vld_reg[ROM_LAT-1:0], grant_a_vld};
            tag_b_vld_reg <= {tag_b_vld_reg[ROM_LAT-1:0], grant_b_vld};
            tag_a_id_reg  <= {tag_a_id_reg[ROM_LAT-1:0], grant_a_id};
            tag_b_id_reg  <= {tag_b_id_reg[ROM_LAT-1:0], grant_b_id};
        end
    end

    assign tag_a_out = tag_a_id_reg[ROM_LAT];
    assign tag_b_out = tag_b_id_reg[ROM_LAT];

    // Nothing new enters the pipes outside RUN, so only entries short of the output slot matter.
    assign drain_done = ~|tag_a_vld_reg[ROM_LAT-1:0] && ~|tag_b_vld_reg[ROM_LAT-1:0];

    always_ff @(posedge read_clk) begin
        if (!rstn) begin
            state_reg            <= ST_RUN;
            iter_sel_reg         <= 1'b0;
            iter_switch_done_reg <= 1'b0;
        end else begin
            iter_switch_done_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (iter_switch_req) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_reg            <= ST_SWITCH;
                        iter_sel_reg         <= ~iter_sel_reg;
                        iter_switch_done_reg <= 1'b1;
                    end
                end
                ST_SWITCH: begin
                    state_reg <= ST_RUN;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_addr_arr[gi]  = bus.req_addr[gi*ADDR_BW +: ADDR_BW];
        assign bus.req_ready[gi] = (grant_a_vld && (grant_a_id == ID_BW'(gi)))
                                || (grant_b_vld && (grant_b_id == ID_BW'(gi)));
        assign hit_a[gi]         = tag_a_vld_reg[ROM_LAT] && (tag_a_out == ID_BW'(gi));
        assign hit_b[gi]         = tag_b_vld_reg[ROM_LAT] && (tag_b_out == ID_BW'(gi));
        assign bus.rsp_valid[gi] = hit_a[gi] || hit_b[gi];
        assign bus.rsp_data[gi*DATA_BW +: DATA_BW] = hit_a[gi] ? bus.rom_portA_dout :
                                                     hit_b[gi] ? bus.rom_portB_dout : '0;
    end

    assign bus.rom_portA_addr = rom_a_addr_reg;
    assign bus.rom_portB_addr = rom_b_addr_reg;
    assign iter_sel           = iter_sel_reg;
    assign iter_switch_done   = iter_switch_done_reg;
    assign busy               = (state_reg != ST_RUN) || (|tag_a_vld_reg) || (|tag_b_vld_reg);

`ifdef ARB_STATS_EN
    logic [CNT_BW-1:0] stall_cnt_reg;
    logic              stall_hit;

    // A stall is any requester left waiting: more than two in RUN, any at all otherwise.
    assign stall_hit = (state_reg == ST_RUN) ? ($countones(bus.req_valid) > 2) : (|bus.req_valid);

    always_ff @(posedge read_clk) begin
        if (!rstn) begin
            stall_cnt_reg <= '0;
        end else if (stall_hit && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_BW'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_ib_rom_port_sched.sv
// Bench for ib_rom_port_sched: per-cycle reference model with scheduled responses,
// plus directed scenarios with literal expectations.
module tb_ib_rom_port_sched;
    localparam int N_REQ   = 4;
    localparam int ADDR_BW = 5;
    localparam int DATA_BW = 6;
    localparam int ROM_LAT = 1;

    logic clk = 1'b0;
    logic rstn;
    logic iter_switch_req;
    logic iter_switch_done;
    logic iter_sel;
    logic busy;
`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif
    logic [ADDR_BW-1:0] addr_tab [N_REQ];
    int n_cmp  = 0;
    int n_fail = 0;

    ib_rom_port_sched_if #(.N_REQ(N_REQ), .ADDR_BW(ADDR_BW), .DATA_BW(DATA_BW)) bus ();

    ib_rom_port_sched #(
        .N_REQ(N_REQ), .ADDR_BW(ADDR_BW), .DATA_BW(DATA_BW), .ROM_LAT(ROM_LAT)
`ifdef ARB_STATS_EN
        , .CNT_BW(16)
`endif
    ) dut (
        .read_clk(clk),
        .rstn(rstn),
        .bus(bus),
        .iter_switch_req(iter_switch_req),
        .iter_switch_done(iter_switch_done),
        .iter_sel(iter_sel),
        .busy(busy)
`ifdef ARB_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_addr
        assign bus.req_addr[gi*ADDR_BW +: ADDR_BW] = addr_tab[gi];
    end

    // ROM stand-in: one registered read stage, word = address + 1.
    always @(posedge clk) begin
        bus.rom_portA_dout <= DATA_BW'(bus.rom_portA_addr) + DATA_BW'(1);
        bus.rom_portB_dout <= DATA_BW'(bus.rom_portB_addr) + DATA_BW'(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: responses are booked two cycles after their handshake; a switch
    // request blocks grants until the cycle after the last booked response, at least two cycles.
    int cyc = 0, m_ptr = 0, m_block_end = -1, m_switch_at = -1, m_last_due = -1, m_stall = 0;
    bit m_iter = 1'b0;
    logic [ADDR_BW-1:0] m_addr_a = '0, m_addr_b = '0;
    bit [N_REQ-1:0] exp_v [64];
    logic [DATA_BW-1:0] exp_d [64][N_REQ];
    int ga, gb, slot, nreq, due;
    bit acc;
    logic [N_REQ-1:0] e_ready;
    logic [N_REQ*DATA_BW-1:0] e_data;
    bit e_busy;

    always @(negedge clk) begin
        slot = cyc % 64;
        if (cyc == m_switch_at) m_iter = ~m_iter;
        acc = rstn && (cyc > m_block_end);
        ga = -1;
        gb = -1;
        if (acc) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (bus.req_valid[(m_ptr + k) % N_REQ]) begin
                    if (ga < 0) ga = (m_ptr + k) % N_REQ;
                    else if (gb < 0) gb = (m_ptr + k) % N_REQ;
                end
            end
        end
        e_ready = '0;
        if (ga >= 0) e_ready[ga] = 1'b1;
        if (gb >= 0) e_ready[gb] = 1'b1;
        e_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_v[slot][i]) e_data[i*DATA_BW +: DATA_BW] = exp_d[slot][i];
        end
        e_busy = (cyc <= m_block_end) || (exp_v[slot] != '0) || (exp_v[(cyc + 1) % 64] != '0);

        chk("m_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(exp_v[slot]));
        chk("m_rsp_data", 32'(bus.rsp_data), 32'(e_data));
        chk("m_addr_a", 32'(bus.rom_portA_addr), 32'(m_addr_a));
        chk("m_addr_b", 32'(bus.rom_portB_addr), 32'(m_addr_b));
        chk("m_iter_sel", 32'(iter_sel), 32'(m_iter));
        chk("m_switch_done", 32'(iter_switch_done), 32'(cyc == m_switch_at));
        chk("m_busy", 32'(busy), 32'(e_busy));
`ifdef ARB_STATS_EN
        chk("m_stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

        if (!rstn) begin
            for (int j = 0; j < 64; j++) exp_v[j] = '0;
            m_ptr = 0; m_iter = 1'b0; m_addr_a = '0; m_addr_b = '0;
            m_block_end = -1; m_switch_at = -1; m_last_due = -1; m_stall = 0;
        end else begin
            exp_v[slot] = '0;
            due = (cyc + 2) % 64;
            if (ga >= 0) begin
                exp_v[due][ga] = 1'b1;
                exp_d[due][ga] = DATA_BW'(addr_tab[ga]) + DATA_BW'(1);
                m_addr_a   = addr_tab[ga];
                m_last_due = cyc + 2;
                m_ptr      = (((gb >= 0) ? gb : ga) + 1) % N_REQ;
            end
            if (gb >= 0) begin
                exp_v[due][gb] = 1'b1;
                exp_d[due][gb] = DATA_BW'(addr_tab[gb]) + DATA_BW'(1);
                m_addr_b = addr_tab[gb];
            end
            if (acc && iter_switch_req) begin
                m_block_end = (m_last_due + 1 > cyc + 2) ? m_last_due + 1 : cyc + 2;
                m_switch_at = m_block_end;
            end
            nreq = $countones(bus.req_valid);
            if ((acc && nreq > 2) || (!acc && nreq > 0)) begin
                if (m_stall < 65535) m_stall++;
            end
            if (ga >= 0) $display("cyc %0d grant A=req%0d B=req%0d", cyc, ga, gb);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            mid();
        end
    endtask

    initial begin
        rstn            = 1'b0;
        iter_switch_req = 1'b0;
        bus.req_valid   = 4'hF;
        addr_tab[0] = 5'd7;
        addr_tab[1] = 5'd11;
        addr_tab[2] = 5'd5;
        addr_tab[3] = 5'd20;

        repeat (3) begin
            mid();
            chk("rst_ready", 32'(bus.req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            chk("rst_iter_sel", 32'(iter_sel), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end

        // Release with all four requesting, then keep the full load on.
        tick(); rstn = 1'b1; mid();
        chk("rel_ready", 32'(bus.req_ready), 32'b0011);
        tick(); mid();
        chk("full_t1_ready", 32'(bus.req_ready), 32'b1100);
        tick(); mid();
        chk("full_t2_ready", 32'(bus.req_ready), 32'b0011);
        tick(); bus.req_valid = 4'h0; mid();
        idle(3);

        // Single read from requester 2.
        tick(); bus.req_valid = 4'b0100; mid();
        chk("single_ready", 32'(bus.req_ready), 32'b0100);
        tick(); bus.req_valid = 4'h0; mid();
        chk("single_addr_a", 32'(bus.rom_portA_addr), 32'd5);
        chk("single_busy", 32'(busy), 32'h1);
        tick(); mid();
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        chk("single_rsp_data", 32'(bus.rsp_data), 32'h006000);
        tick(); mid();
        chk("single_rsp_gone", 32'(bus.rsp_valid), 32'h0);
        chk("single_idle_busy", 32'(busy), 32'h0);

        // Two requesters held: both served every cycle.
        repeat (20) begin
            tick(); bus.req_valid = 4'b1001; mid();
            chk("fair_ready", 32'(bus.req_ready), 32'b1001);
        end
        tick(); bus.req_valid = 4'h0; mid();
        idle(3);

        // Table switch with two reads in flight; a second request in DRAIN is ignored.
        tick(); bus.req_valid = 4'b0011; iter_switch_req = 1'b1; mid();
        chk("sw_t_ready", 32'(bus.req_ready), 32'b0011);
        tick(); iter_switch_req = 1'b0; mid();
        chk("sw_t1_ready", 32'(bus.req_ready), 32'h0);
        chk("sw_t1_busy", 32'(busy), 32'h1);
        tick(); iter_switch_req = 1'b1; mid();
        chk("sw_t2_ready", 32'(bus.req_ready), 32'h0);
        chk("sw_t2_rsp", 32'(bus.rsp_valid), 32'b0011);
        tick(); iter_switch_req = 1'b0; mid();
        chk("sw_t3_ready", 32'(bus.req_ready), 32'h0);
        chk("sw_t3_iter_sel", 32'(iter_sel), 32'h1);
        chk("sw_t3_done", 32'(iter_switch_done), 32'h1);
        tick(); mid();
        chk("sw_t4_ready", 32'(bus.req_ready), 32'b0011);
        chk("sw_t4_done", 32'(iter_switch_done), 32'h0);
        tick(); bus.req_valid = 4'h0; mid();
        idle(3);

        // Table switch with nothing in flight: one DRAIN cycle, then SWITCH.
        tick(); iter_switch_req = 1'b1; mid();
        chk("sw0_busy", 32'(busy), 32'h0);
        tick(); iter_switch_req = 1'b0; bus.req_valid = 4'b0001; mid();
        chk("sw0_u1_ready", 32'(bus.req_ready), 32'h0);
        chk("sw0_u1_busy", 32'(busy), 32'h1);
        tick(); mid();
        chk("sw0_u2_ready", 32'(bus.req_ready), 32'h0);
        chk("sw0_u2_done", 32'(iter_switch_done), 32'h1);
        chk("sw0_u2_iter_sel", 32'(iter_sel), 32'h0);
        tick(); mid();
        chk("sw0_u3_ready", 32'(bus.req_ready), 32'b0001);
        tick(); bus.req_valid = 4'h0; mid();
        idle(3);

        // Reset while a read is in flight: its response must never appear.
        tick(); bus.req_valid = 4'b0100; mid();
        chk("rmid_ready", 32'(bus.req_ready), 32'b0100);
        tick(); rstn = 1'b0; bus.req_valid = 4'h0; mid();
        chk("rmid_rst_ready", 32'(bus.req_ready), 32'h0);
        tick(); mid();
        chk("rmid_no_rsp", 32'(bus.rsp_valid), 32'h0);
        chk("rmid_busy", 32'(busy), 32'h0);
        tick(); rstn = 1'b1; bus.req_valid = 4'hF; mid();
        chk("rmid_ptr_ready", 32'(bus.req_ready), 32'b0011);
        tick(); bus.req_valid = 4'h0; mid();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
